// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DMA  = 1;
    localparam int unsigned NUM_PORTS = 2;

endpackage : dmem_arb_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to the
// port that did not win last time.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == 1'(PORT_DMA)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arbiter2

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a DMA/debug port onto one data-memory interface,
// one outstanding transaction at a time (IDLE -> ACCESS -> RESP).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        req_c;
    logic [1:0]        grant_c;
    logic [1:0]        ready_c;
    logic [1:0]        rsp_valid_c;
    logic              handshake_c;
    logic              err_c;
    logic              access_ok_c;
    logic              rsp_ready_c;

    // Reset asserts asynchronously, releases two edges later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign req_c = {req1_valid, req0_valid} & {2{rst_n_int}};

    rr_arbiter2 u_rr (
        .req   (req_c),
        .last  (last_q),
        .grant (grant_c)
    );

    assign ready_c     = (state_q == IDLE) ? grant_c : 2'b00;
    assign handshake_c = |ready_c;
    assign err_c       = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_W'(MEM_BYTES));
    assign access_ok_c = (state_q == ACCESS) && !err_c;
    assign rsp_ready_c = (owner_q == 1'(PORT_DMA)) ? rsp1_ready : rsp0_ready;

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state: latch on grant, capture read data, hold response until taken
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (handshake_c) begin
                    state_d = ACCESS;
                    owner_d = grant_c[PORT_DMA];
                    last_d  = grant_c[PORT_DMA];
                    we_d    = grant_c[PORT_DMA] ? req1_we    : req0_we;
                    addr_d  = grant_c[PORT_DMA] ? req1_addr  : req0_addr;
                    wdata_d = grant_c[PORT_DMA] ? req1_wdata : req0_wdata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = (access_ok_c && !we_q) ? readData : '0;
                err_d   = err_c;
            end
            RESP: begin
                if (rsp_ready_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid_c[PORT_CORE] = (state_q == RESP) && (owner_q == 1'(PORT_CORE));
    assign rsp_valid_c[PORT_DMA]  = (state_q == RESP) && (owner_q == 1'(PORT_DMA));

    assign req0_ready = ready_c[PORT_CORE];
    assign req1_ready = ready_c[PORT_DMA];

    assign rsp0_valid = rsp_valid_c[PORT_CORE];
    assign rsp0_rdata = rsp_valid_c[PORT_CORE] ? rdata_q : '0;
    assign rsp0_err   = rsp_valid_c[PORT_CORE] && err_q;
    assign rsp1_valid = rsp_valid_c[PORT_DMA];
    assign rsp1_rdata = rsp_valid_c[PORT_DMA] ? rdata_q : '0;
    assign rsp1_err   = rsp_valid_c[PORT_DMA] && err_q;

    assign MemRead   = access_ok_c && !we_q;
    assign MemWrite  = access_ok_c && we_q;
    assign Address   = access_ok_c ? addr_q  : '0;
    assign writeData = access_ok_c ? wdata_q : '0;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        MemWrite, MemRead;
    logic [31:0] Address, writeData, readData;

    logic [31:0] mem     [64] = '{default: 32'h0};
    logic [31:0] exp_mem [64] = '{default: 32'h0};
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    bit chk_en   = 1'b0;

    // model state
    bit          m_busy = 1'b0;
    int          m_age = 0, m_port = 0, m_last = 1, m_live = 0;
    bit          m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    // monitor records
    int q_grants[$];
    int mr_cnt = 0, mw_cnt = 0, r0_cnt = 0, r1_cnt = 0;
    logic [31:0] mr_addr = '0, r0_data = '0, r1_data = '0;
    logic r0_err = 1'b0, r1_err = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
        .writeData(writeData), .readData(readData)
    );

    // Memory the arbiter drives
    assign readData = MemRead ? mem[Address[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (MemWrite) mem[Address[7:2]] <= writeData;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Arbitration rule: lone requester wins, contention goes away from last winner
    function automatic int pick(input bit v0, input bit v1, input int last);
        if (v0 && v1) return 1 - last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Transaction-level model advanced on each edge
    always @(posedge clk or negedge reset) begin
        int p;
        bit active;
        if (pl_en) exp_mem[pl_idx] = pl_data;
        if (!reset) begin
            m_busy = 1'b0;
            m_last = 1;
            m_live = 0;
        end else begin
            active = (m_live >= 2);
            if (m_busy) begin
                if (m_age == 0) begin
                    m_age = 1;
                    if (!m_err && m_we) exp_mem[m_addr[7:2]] = m_wdata;
                    m_rdata = (!m_err && !m_we) ? exp_mem[m_addr[7:2]] : 32'h0;
                end else if ((m_port == 0) ? rsp0_ready : rsp1_ready) begin
                    m_busy = 1'b0;
                end
            end else if (active) begin
                p = pick(req0_valid, req1_valid, m_last);
                if (p >= 0) begin
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_port  = p;
                    m_we    = (p == 0) ? req0_we : req1_we;
                    m_addr  = (p == 0) ? req0_addr : req1_addr;
                    m_wdata = (p == 0) ? req0_wdata : req1_wdata;
                    m_err   = (m_addr[1:0] != 2'b00) || (m_addr >= 32'd256);
                    m_last  = p;
                end
            end
            if (m_live < 2) m_live++;
        end
    end

    // Per-cycle comparison against the model, plus event recording
    always @(negedge clk) begin
        bit e_rdy0, e_rdy1, acc, rsp;
        int p;
        if (chk_en) begin
            if (req0_valid && req0_ready) q_grants.push_back(0);
            if (req1_valid && req1_ready) q_grants.push_back(1);
            if (MemRead) begin mr_cnt++; mr_addr = Address; end
            if (MemWrite) mw_cnt++;
            if (rsp0_valid) begin r0_cnt++; r0_data = rsp0_rdata; r0_err = rsp0_err; end
            if (rsp1_valid) begin r1_cnt++; r1_data = rsp1_rdata; r1_err = rsp1_err; end

            p = pick(req0_valid, req1_valid, m_last);
            e_rdy0 = reset && (m_live >= 2) && !m_busy && (p == 0);
            e_rdy1 = reset && (m_live >= 2) && !m_busy && (p == 1);
            acc    = reset && m_busy && (m_age == 0) && !m_err;
            rsp    = reset && m_busy && (m_age >= 1);
            check("cyc_ready0", 32'(req0_ready), 32'(e_rdy0));
            check("cyc_ready1", 32'(req1_ready), 32'(e_rdy1));
            check("cyc_memrd", 32'(MemRead), 32'(acc && !m_we));
            check("cyc_memwr", 32'(MemWrite), 32'(acc && m_we));
            check("cyc_addr", Address, acc ? m_addr : 32'h0);
            check("cyc_wdata", writeData, acc ? m_wdata : 32'h0);
            check("cyc_rsp0_valid", 32'(rsp0_valid), 32'(rsp && m_port == 0));
            check("cyc_rsp1_valid", 32'(rsp1_valid), 32'(rsp && m_port == 1));
            check("cyc_rsp0_rdata", rsp0_rdata, (rsp && m_port == 0) ? m_rdata : 32'h0);
            check("cyc_rsp1_rdata", rsp1_rdata, (rsp && m_port == 1) ? m_rdata : 32'h0);
            check("cyc_rsp0_err", 32'(rsp0_err), 32'(rsp && m_port == 0 && m_err));
            check("cyc_rsp1_err", 32'(rsp1_err), 32'(rsp && m_port == 1 && m_err));
        end
    end

    task automatic set_req(input int p, input bit v, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Present a request, wait for acceptance; keep=1 leaves valid high
    task automatic do_req(input int p, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input bit keep);
        bit got = 1'b0;
        set_req(p, 1'b1, we, a, d);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_bound($sformatf("req%0d_accept", p));
        hs_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(posedge clk);
        #1;
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    initial begin
        int g0, mr0, mw0, r1c;
        bit got;
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        preload(6'd2, 32'h12345678);
        preload(6'd3, 32'hDEADBEEF);

        // Outputs held low in reset even with a request pending
        req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'h0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("rst_memrd", 32'(MemRead), 32'h0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Contention: both ports hold valid through store then load
        g0 = q_grants.size();
        fork
            begin do_req(0, 1'b1, 32'h00, 32'h11, 1'b1); do_req(0, 1'b0, 32'h00, 32'h0, 1'b0); end
            begin do_req(1, 1'b1, 32'h04, 32'h22, 1'b1); do_req(1, 1'b0, 32'h04, 32'h0, 1'b0); end
        join
        settle();
        if (q_grants.size() >= g0 + 4) begin
            check("cont_grant0", 32'(q_grants[g0]), 32'd0);
            check("cont_grant1", 32'(q_grants[g0+1]), 32'd1);
            check("cont_grant2", 32'(q_grants[g0+2]), 32'd0);
            check("cont_grant3", 32'(q_grants[g0+3]), 32'd1);
        end else begin
            check("cont_grant_count", 32'(q_grants.size() - g0), 32'd4);
        end
        check("cont_mem0", mem[0], 32'h11);
        check("cont_mem1", mem[1], 32'h22);
        check("cont_load0", r0_data, 32'h11);
        check("cont_load1", r1_data, 32'h22);

        // Single load from word 3
        mr0 = mr_cnt;
        do_req(0, 1'b0, 32'h0C, 32'h0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                got = 1'b1;
                check("load_latency", 32'(cyc - hs_cyc), 32'd1);
                check("load_rdata", rsp0_rdata, 32'hDEADBEEF);
                break;
            end
        end
        if (!got) fail_bound("load_rsp0_valid");
        settle();
        check("load_memrd_cycles", 32'(mr_cnt - mr0), 32'd1);
        check("load_memrd_addr", mr_addr, 32'h0C);

        // Misaligned, out-of-range store from port 1
        mw0 = mw_cnt;
        r1c = r1_cnt;
        do_req(1, 1'b1, 32'h102, 32'hBAD0BAD0, 1'b0);
        settle();
        check("err_memwr_cycles", 32'(mw_cnt - mw0), 32'd0);
        check("err_rsp_cycles", 32'(r1_cnt - r1c), 32'd1);
        check("err_flag", 32'(r1_err), 32'd1);
        check("err_rdata", r1_data, 32'h0);

        // Back-pressure on port 0 with port 1 waiting
        rsp0_ready = 1'b0;
        do_req(0, 1'b0, 32'h0C, 32'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 32'h04, 32'h0);
        @(negedge clk);
        check("bp_access_ready1", 32'(req1_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp0_valid", 32'(rsp0_valid), 32'h1);
            check("bp_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
            check("bp_ready1", 32'(req1_ready), 32'h0);
        end
        @(posedge clk);
        #1 rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp0_valid), 32'h1);
        check("bp_release_ready1", 32'(req1_ready), 32'h0);
        @(negedge clk);
        check("bp_idle_valid", 32'(rsp0_valid), 32'h0);
        check("bp_idle_ready1", 32'(req1_ready), 32'h1);
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("bp_load1", r1_data, 32'h22);

        // Reset in the middle of a store access
        do_req(0, 1'b1, 32'h08, 32'hCAFE0000, 1'b0);
        #1;
        check("mid_memwr_before", 32'(MemWrite), 32'h1);
        check("mid_addr_before", Address, 32'h08);
        check("mid_wdata_before", writeData, 32'hCAFE0000);
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h08, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h04, 32'h0);
        #1;
        check("mid_memwr", 32'(MemWrite), 32'h0);
        check("mid_memrd", 32'(MemRead), 32'h0);
        check("mid_addr", Address, 32'h0);
        check("mid_wdata", writeData, 32'h0);
        check("mid_ready0", 32'(req0_ready), 32'h0);
        check("mid_ready1", 32'(req1_ready), 32'h0);
        check("mid_rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("mid_rsp0_rdata", rsp0_rdata, 32'h0);
        check("mid_rsp0_err", 32'(rsp0_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_word2", mem[2], 32'h12345678);
        reset = 1'b1;
        g0 = q_grants.size();
        fork
            do_req(0, 1'b0, 32'h08, 32'h0, 1'b0);
            do_req(1, 1'b0, 32'h04, 32'h0, 1'b0);
        join
        settle();
        if (q_grants.size() >= g0 + 2) begin
            check("post_rst_grant0", 32'(q_grants[g0]), 32'd0);
            check("post_rst_grant1", 32'(q_grants[g0+1]), 32'd1);
        end else begin
            check("post_rst_grant_count", 32'(q_grants.size() - g0), 32'd2);
        end
        check("post_rst_load0", r0_data, 32'h12345678);

        for (int i = 0; i < 4; i++) check($sformatf("final_mem%0d", i), mem[i], exp_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
